// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: after power-up it hands the command/address/data pins to the init,
// auto-refresh, write and read engines one at a time. Refresh has top priority and write/read
// alternate when both are pending.
module sdram_arbit #(
    parameter logic [3:0]  CMD_NOP = 4'b0111,
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned DQ_W    = 16
) (
    input  logic              i_sysclk,
    input  logic              i_sysrst_n,
    // init engine
    input  logic              i_init_done,
    input  logic [3:0]        i_init_cmd,
    input  logic [1:0]        i_init_ba,
    input  logic [ADDR_W-1:0] i_init_addr,
    // auto-refresh engine
    input  logic              i_aref_req,
    input  logic              i_aref_end,
    input  logic [3:0]        i_aref_cmd,
    input  logic [ADDR_W-1:0] i_aref_addr,
    // write engine
    input  logic              i_wr_req,
    input  logic              i_wr_end,
    input  logic [3:0]        i_wr_cmd,
    input  logic [1:0]        i_wr_ba,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic              i_wr_sdram_en,
    input  logic [DQ_W-1:0]   i_wr_sdram_data,
    // read engine
    input  logic              i_rd_req,
    input  logic              i_rd_end,
    input  logic [3:0]        i_rd_cmd,
    input  logic [1:0]        i_rd_ba,
    input  logic [ADDR_W-1:0] i_rd_addr,
    // grants
    output logic              o_aref_en,
    output logic              o_wr_en,
    output logic              o_rd_en,
    output logic [DQ_W-1:0]   o_rd_data,
    // device pins
    output logic              o_sdram_cke,
    output logic              o_sdram_cs_n,
    output logic              o_sdram_ras_n,
    output logic              o_sdram_cas_n,
    output logic              o_sdram_we_n,
    output logic [1:0]        o_sdram_ba,
    output logic [ADDR_W-1:0] o_sdram_addr,
    inout  wire  [DQ_W-1:0]   sdram_dq
);

    typedef enum logic [2:0] {
        StInit,
        StArbit,
        StAref,
        StWrite,
        StRead
    } state_e;

    state_e     state_q;
    logic       last_wr_q;
    logic [3:0] cmd;

    // Arbitration FSM with registered grants; every grant returns through StArbit so the bus
    // sees at least one NOP cycle between owners.
    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            state_q   <= StInit;
            o_aref_en <= 1'b0;
            o_wr_en   <= 1'b0;
            o_rd_en   <= 1'b0;
            last_wr_q <= 1'b0;
        end else begin
            case (state_q)
                StInit: begin
                    // init_done is only looked at here, so it is effectively sticky
                    if (i_init_done) begin
                        state_q <= StArbit;
                    end
                end
                StArbit: begin
                    if (i_aref_req) begin
                        state_q   <= StAref;
                        o_aref_en <= 1'b1;
                    end else if (i_wr_req && (!i_rd_req || !last_wr_q)) begin
                        state_q   <= StWrite;
                        o_wr_en   <= 1'b1;
                        last_wr_q <= 1'b1;
                    end else if (i_rd_req) begin
                        state_q   <= StRead;
                        o_rd_en   <= 1'b1;
                        last_wr_q <= 1'b0;
                    end
                end
                StAref: begin
                    if (i_aref_end) begin
                        state_q   <= StArbit;
                        o_aref_en <= 1'b0;
                    end
                end
                StWrite: begin
                    if (i_wr_end) begin
                        state_q <= StArbit;
                        o_wr_en <= 1'b0;
                    end
                end
                StRead: begin
                    if (i_rd_end) begin
                        state_q <= StArbit;
                        o_rd_en <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StInit;
                    o_aref_en <= 1'b0;
                    o_wr_en   <= 1'b0;
                    o_rd_en   <= 1'b0;
                end
            endcase
        end
    end

    // Pin mux: owner's command/bank/address; NOP while arbitrating or held in reset.
    always_comb begin
        cmd          = CMD_NOP;
        o_sdram_ba   = 2'b11;
        o_sdram_addr = {ADDR_W{1'b1}};
        if (i_sysrst_n) begin
            case (state_q)
                StInit: begin
                    cmd          = i_init_cmd;
                    o_sdram_ba   = i_init_ba;
                    o_sdram_addr = i_init_addr;
                end
                StAref: begin
                    cmd          = i_aref_cmd;
                    o_sdram_addr = i_aref_addr;
                end
                StWrite: begin
                    cmd          = i_wr_cmd;
                    o_sdram_ba   = i_wr_ba;
                    o_sdram_addr = i_wr_addr;
                end
                StRead: begin
                    cmd          = i_rd_cmd;
                    o_sdram_ba   = i_rd_ba;
                    o_sdram_addr = i_rd_addr;
                end
                default: begin
                    cmd = CMD_NOP;
                end
            endcase
        end
    end

    assign {o_sdram_cs_n, o_sdram_ras_n, o_sdram_cas_n, o_sdram_we_n} = cmd;
    assign o_sdram_cke = 1'b1;

    // Only the write engine ever drives the data bus.
    assign sdram_dq = (state_q == StWrite && i_wr_sdram_en) ? i_wr_sdram_data : {DQ_W{1'bz}};

    // Read data capture: the bus is sampled every cycle, the read engine picks what it needs.
    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            o_rd_data <= '0;
        end else begin
            o_rd_data <= sdram_dq;
        end
    end

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: directed scenarios plus a randomized run against a grant-level model.
module tb_sdram_arbit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_done;
    logic [3:0]  init_cmd;
    logic [1:0]  init_ba;
    logic [12:0] init_addr;
    logic        aref_req, aref_end;
    logic [3:0]  aref_cmd;
    logic [12:0] aref_addr;
    logic        wr_req, wr_end;
    logic [3:0]  wr_cmd;
    logic [1:0]  wr_ba;
    logic [12:0] wr_addr;
    logic        wr_sdram_en;
    logic [15:0] wr_sdram_data;
    logic        rd_req, rd_end;
    logic [3:0]  rd_cmd;
    logic [1:0]  rd_ba;
    logic [12:0] rd_addr;
    logic        aref_en, wr_en, rd_en;
    logic [15:0] rd_data;
    logic        cke, cs_n, ras_n, cas_n, we_n;
    logic [1:0]  ba;
    logic [12:0] addr;
    wire  [15:0] sdram_dq;
    logic        tb_dq_en;
    logic [15:0] tb_dq;

    // Device-side model of the bus: drives a pattern whenever the controller should be off it.
    assign sdram_dq = tb_dq_en ? tb_dq : 16'hzzzz;

    always #5 clk = ~clk;

    sdram_arbit dut (
        .i_sysclk        (clk),
        .i_sysrst_n      (rst_n),
        .i_init_done     (init_done),
        .i_init_cmd      (init_cmd),
        .i_init_ba       (init_ba),
        .i_init_addr     (init_addr),
        .i_aref_req      (aref_req),
        .i_aref_end      (aref_end),
        .i_aref_cmd      (aref_cmd),
        .i_aref_addr     (aref_addr),
        .i_wr_req        (wr_req),
        .i_wr_end        (wr_end),
        .i_wr_cmd        (wr_cmd),
        .i_wr_ba         (wr_ba),
        .i_wr_addr       (wr_addr),
        .i_wr_sdram_en   (wr_sdram_en),
        .i_wr_sdram_data (wr_sdram_data),
        .i_rd_req        (rd_req),
        .i_rd_end        (rd_end),
        .i_rd_cmd        (rd_cmd),
        .i_rd_ba         (rd_ba),
        .i_rd_addr       (rd_addr),
        .o_aref_en       (aref_en),
        .o_wr_en         (wr_en),
        .o_rd_en         (rd_en),
        .o_rd_data       (rd_data),
        .o_sdram_cke     (cke),
        .o_sdram_cs_n    (cs_n),
        .o_sdram_ras_n   (ras_n),
        .o_sdram_cas_n   (cas_n),
        .o_sdram_we_n    (we_n),
        .o_sdram_ba      (ba),
        .o_sdram_addr    (addr),
        .sdram_dq        (sdram_dq)
    );

    // Reference model: who owns the bus (0 nobody, 1 refresh, 2 write, 3 read).
    bit m_inited;
    int m_owner;
    bit m_last_wr;
    int checks = 0;
    int errors = 0;

    function automatic bit m_dut_drives();
        return m_inited && m_owner == 2 && wr_sdram_en;
    endfunction

    // Apply one clock edge of the arbitration rules to the model.
    function automatic void model_step();
        if (!m_inited) begin
            if (init_done) m_inited = 1'b1;
        end else if (m_owner == 0) begin
            if (aref_req) begin
                m_owner = 1;
            end else if (wr_req && rd_req) begin
                m_owner   = m_last_wr ? 3 : 2;
                m_last_wr = !m_last_wr;
            end else if (wr_req) begin
                m_owner   = 2;
                m_last_wr = 1'b1;
            end else if (rd_req) begin
                m_owner   = 3;
                m_last_wr = 1'b0;
            end
        end else if ((m_owner == 1 && aref_end) || (m_owner == 2 && wr_end) ||
                     (m_owner == 3 && rd_end)) begin
            m_owner = 0;
        end
    endfunction

    function automatic void model_reset();
        m_inited  = 1'b0;
        m_owner   = 0;
        m_last_wr = 1'b0;
    endfunction

    // One clock cycle: check pins and bus against the model, clock, then check grants and capture.
    task automatic tick();
        logic [18:0] e_pins;
        logic [15:0] e_bus;
        logic [2:0]  e_en;
        tb_dq_en = !m_dut_drives();
        tb_dq    = 16'($urandom);
        #1;
        if (!m_inited)         e_pins = {init_cmd, init_ba, init_addr};
        else if (m_owner == 1) e_pins = {aref_cmd, 2'b11, aref_addr};
        else if (m_owner == 2) e_pins = {wr_cmd, wr_ba, wr_addr};
        else if (m_owner == 3) e_pins = {rd_cmd, rd_ba, rd_addr};
        else                   e_pins = {4'b0111, 2'b11, 13'h1fff};
        checks++;
        if ({cs_n, ras_n, cas_n, we_n, ba, addr} !== e_pins) begin
            errors++;
            $display("FAIL pins: got %h expected %h (t=%0t)",
                     {cs_n, ras_n, cas_n, we_n, ba, addr}, e_pins, $time);
        end
        e_bus = tb_dq_en ? tb_dq : wr_sdram_data;
        checks++;
        if (sdram_dq !== e_bus) begin
            errors++;
            $display("FAIL dq_bus: got %h expected %h (t=%0t)", sdram_dq, e_bus, $time);
        end
        checks++;
        if (cke !== 1'b1) begin
            errors++;
            $display("FAIL cke: got %b expected 1", cke);
        end
        model_step();
        @(posedge clk);
        #1;
        e_en = {m_owner == 1, m_owner == 2, m_owner == 3};
        checks++;
        if ({aref_en, wr_en, rd_en} !== e_en) begin
            errors++;
            $display("FAIL grants: got %b expected %b (t=%0t)",
                     {aref_en, wr_en, rd_en}, e_en, $time);
        end
        checks++;
        if (rd_data !== e_bus) begin
            errors++;
            $display("FAIL rd_data: got %h expected %h (t=%0t)", rd_data, e_bus, $time);
        end
    endtask

    task automatic test_reset();
        tb_dq_en = 1'b1;
        tb_dq    = 16'h3c3c;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({aref_en, wr_en, rd_en} !== 3'b000) begin
            errors++;
            $display("FAIL reset_grants: got %b expected 000", {aref_en, wr_en, rd_en});
        end
        checks++;
        if ({cs_n, ras_n, cas_n, we_n, ba, addr} !== {4'b0111, 2'b11, 13'h1fff}) begin
            errors++;
            $display("FAIL reset_pins: got %h expected %h",
                     {cs_n, ras_n, cas_n, we_n, ba, addr}, {4'b0111, 2'b11, 13'h1fff});
        end
        checks++;
        if (rd_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rd_data: got %h expected 0000", rd_data);
        end
        checks++;
        if (sdram_dq !== 16'h3c3c) begin
            errors++;
            $display("FAIL reset_dq_released: got %h expected 3c3c", sdram_dq);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_init_hold();
        init_done = 1'b0;
        init_cmd  = 4'b0010;
        init_ba   = 2'b01;
        init_addr = 13'h0400;
        repeat (3) tick();
        #1;
        checks++;
        if ({cs_n, ras_n, cas_n, we_n} !== 4'b0010 || {aref_en, wr_en, rd_en} !== 3'b000) begin
            errors++;
            $display("FAIL init_hold: got cmd %b en %b expected cmd 0010 en 000",
                     {cs_n, ras_n, cas_n, we_n}, {aref_en, wr_en, rd_en});
        end
    endtask

    task automatic test_tie_alternate();
        init_done = 1'b1;
        wr_req    = 1'b1;
        rd_req    = 1'b1;
        tick();
        init_done = 1'b0;
        checks++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL tie_wr_early: got %b expected 0", wr_en);
        end
        tick();
        checks++;
        if (wr_en !== 1'b1) begin
            errors++;
            $display("FAIL tie_first_write: got %b expected 1", wr_en);
        end
        repeat (2) tick();
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        checks++;
        if (wr_en !== 1'b0 || {cs_n, ras_n, cas_n, we_n} !== 4'b0111) begin
            errors++;
            $display("FAIL tie_arbit_nop: got en %b cmd %b expected en 0 cmd 0111",
                     wr_en, {cs_n, ras_n, cas_n, we_n});
        end
        tick();
        checks++;
        if (rd_en !== 1'b1) begin
            errors++;
            $display("FAIL tie_then_read: got %b expected 1", rd_en);
        end
        rd_end = 1'b1;
        tick();
        rd_end = 1'b0;
        tick();
        checks++;
        if (wr_en !== 1'b1) begin
            errors++;
            $display("FAIL tie_write_again: got %b expected 1", wr_en);
        end
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        tick();
        rd_end = 1'b1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        tick();
        rd_end = 1'b0;
        tick();
    endtask

    task automatic test_aref_priority();
        aref_req = 1'b1;
        wr_req   = 1'b1;
        rd_req   = 1'b1;
        aref_cmd = 4'b0001;
        tick();
        checks++;
        if ({aref_en, wr_en, rd_en} !== 3'b100 || {cs_n, ras_n, cas_n, we_n, ba} !== 6'b000111)
        begin
            errors++;
            $display("FAIL aref_first: got en %b cmd/ba %b expected en 100 cmd/ba 000111",
                     {aref_en, wr_en, rd_en}, {cs_n, ras_n, cas_n, we_n, ba});
        end
        tick();
        aref_end = 1'b1;
        aref_req = 1'b0;
        tick();
        aref_end = 1'b0;
        tick();
        checks++;
        if ({aref_en, wr_en, rd_en} !== 3'b010) begin
            errors++;
            $display("FAIL aref_then_write: got %b expected 010", {aref_en, wr_en, rd_en});
        end
        wr_end = 1'b1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        tick();
        wr_end = 1'b0;
        tick();
    endtask

    task automatic test_dq();
        wr_req        = 1'b1;
        wr_sdram_data = 16'ha5a5;
        tick();
        wr_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_sdram_en = i[0];
            tb_dq_en    = !i[0];
            tb_dq       = 16'h1234;
            #1;
            checks++;
            if (sdram_dq !== (i[0] ? 16'ha5a5 : 16'h1234)) begin
                errors++;
                $display("FAIL dq_toggle: got %h expected %h (en=%0d)",
                         sdram_dq, (i[0] ? 16'ha5a5 : 16'h1234), i[0]);
            end
            tick();
        end
        wr_sdram_en = 1'b0;
        wr_end      = 1'b1;
        tick();
        wr_end = 1'b0;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        repeat (4) tick();
        rd_end = 1'b1;
        tick();
        rd_end = 1'b0;
        tick();
    endtask

    task automatic test_aref_mid_write();
        wr_req = 1'b1;
        tick();
        wr_req   = 1'b0;
        aref_req = 1'b1;
        repeat (3) tick();
        checks++;
        if ({aref_en, wr_en} !== 2'b01) begin
            errors++;
            $display("FAIL aref_waits: got %b expected 01", {aref_en, wr_en});
        end
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        checks++;
        if (aref_en !== 1'b0) begin
            errors++;
            $display("FAIL aref_edge1: got %b expected 0", aref_en);
        end
        tick();
        checks++;
        if (aref_en !== 1'b1) begin
            errors++;
            $display("FAIL aref_edge2: got %b expected 1", aref_en);
        end
        aref_end = 1'b1;
        aref_req = 1'b0;
        tick();
        aref_end = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_read();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        checks++;
        if (rd_en !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_read: got %b expected 1", rd_en);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({aref_en, wr_en, rd_en} !== 3'b000 ||
            {cs_n, ras_n, cas_n, we_n, ba, addr} !== {4'b0111, 2'b11, 13'h1fff}) begin
            errors++;
            $display("FAIL async_reset: got en %b pins %h expected en 000 pins %h",
                     {aref_en, wr_en, rd_en}, {cs_n, ras_n, cas_n, we_n, ba, addr},
                     {4'b0111, 2'b11, 13'h1fff});
        end
        tb_dq_en = 1'b1;
        tb_dq    = 16'h0ff0;
        @(posedge clk);
        #1;
        checks++;
        if (rd_data !== 16'h0000 || sdram_dq !== 16'h0ff0) begin
            errors++;
            $display("FAIL reset_hold: got rd_data %h dq %h expected 0000 0ff0", rd_data, sdram_dq);
        end
        rst_n     = 1'b1;
        init_done = 1'b0;
        rd_req    = 1'b1;
        wr_req    = 1'b1;
        init_cmd  = 4'b0010;
        repeat (3) tick();
        rd_req = 1'b0;
        wr_req = 1'b0;
    endtask

    task automatic test_random();
        init_done = 1'b1;
        tick();
        for (int i = 0; i < 500; i++) begin
            init_done     = 1'($urandom);
            aref_req      = ($urandom_range(99) < 15);
            wr_req        = ($urandom_range(99) < 50);
            rd_req        = ($urandom_range(99) < 50);
            aref_end      = ($urandom_range(99) < 30);
            wr_end        = ($urandom_range(99) < 30);
            rd_end        = ($urandom_range(99) < 30);
            init_cmd      = 4'($urandom);
            init_ba       = 2'($urandom);
            init_addr     = 13'($urandom);
            aref_cmd      = 4'($urandom);
            aref_addr     = 13'($urandom);
            wr_cmd        = 4'($urandom);
            wr_ba         = 2'($urandom);
            wr_addr       = 13'($urandom);
            wr_sdram_en   = 1'($urandom);
            wr_sdram_data = 16'($urandom);
            rd_cmd        = 4'($urandom);
            rd_ba         = 2'($urandom);
            rd_addr       = 13'($urandom);
            tick();
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        init_done     = 1'b0;
        init_cmd      = 4'b0111;
        init_ba       = 2'b00;
        init_addr     = 13'h0000;
        aref_req      = 1'b0;
        aref_end      = 1'b0;
        aref_cmd      = 4'b0111;
        aref_addr     = 13'h0abc;
        wr_req        = 1'b0;
        wr_end        = 1'b0;
        wr_cmd        = 4'b0100;
        wr_ba         = 2'b10;
        wr_addr       = 13'h0123;
        wr_sdram_en   = 1'b0;
        wr_sdram_data = 16'h0000;
        rd_req        = 1'b0;
        rd_end        = 1'b0;
        rd_cmd        = 4'b0101;
        rd_ba         = 2'b01;
        rd_addr       = 13'h0456;
        tb_dq_en      = 1'b1;
        tb_dq         = 16'h0000;
        model_reset();

        test_reset();
        test_init_hold();
        test_tie_alternate();
        test_aref_priority();
        test_dq();
        test_aref_mid_write();
        test_reset_mid_read();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_arbit.md
Name: sdram_arbit

Overview:
- Owns the SDRAM command/address/data pins after power-up.
- Sequences the init, auto-refresh, write and read sub-modules of the SDRAM controller, granting the bus to one at a time.
- Priority: refresh > write/read; write and read alternate when both are pending.
- Sits between the sub-modules and the device pins inside sdram_ctrl.

Parameters:
- CMD_NOP, 4'b0111, {cs_n,ras_n,cas_n,we_n} idle command
- ADDR_W, 13, SDRAM address width
- DQ_W, 16, SDRAM data width

Ports:
- i_sysclk  in  1  system clock, 100 MHz
- i_sysrst_n  in  1  asynchronous active-low reset
- i_init_done  in  1  init sequence finished
- i_init_cmd  in  4  init command
- i_init_ba  in  2  init bank
- i_init_addr  in  ADDR_W  init address
- i_aref_req  in  1  refresh request
- i_aref_end  in  1  refresh finished, 1-cycle pulse
- i_aref_cmd  in  4  refresh command
- i_aref_addr  in  ADDR_W  refresh address
- i_wr_req  in  1  write request
- i_wr_end  in  1  write finished, 1-cycle pulse
- i_wr_cmd  in  4  write command
- i_wr_ba  in  2  write bank
- i_wr_addr  in  ADDR_W  write address
- i_wr_sdram_en  in  1  write data output enable
- i_wr_sdram_data  in  DQ_W  write data
- i_rd_req  in  1  read request
- i_rd_end  in  1  read finished, 1-cycle pulse
- i_rd_cmd  in  4  read command
- i_rd_ba  in  2  read bank
- i_rd_addr  in  ADDR_W  read address
- o_aref_en  out  1  refresh grant
- o_wr_en  out  1  write grant
- o_rd_en  out  1  read grant
- o_rd_data  out  DQ_W  sdram_dq sampled every cycle
- o_sdram_cke  out  1  clock enable, constant 1
- o_sdram_cs_n  out  1  chip select, cmd[3]
- o_sdram_ras_n  out  1  row address strobe, cmd[2]
- o_sdram_cas_n  out  1  column address strobe, cmd[1]
- o_sdram_we_n  out  1  write enable, cmd[0]
- o_sdram_ba  out  2  bank address
- o_sdram_addr  out  ADDR_W  address
- sdram_dq  inout  DQ_W  device data bus

Behaviour:
- Reset (asynchronous):
  - state = INIT; o_aref_en, o_wr_en, o_rd_en = 0; last_wr = 0.
  - cmd = CMD_NOP, o_sdram_ba = 2'b11, o_sdram_addr = all ones; o_rd_data = 0; sdram_dq = Z.
  - o_sdram_cke = 1 always.
- State machine registers: INIT, ARBIT, AREF, WRITE, READ.
- INIT:
  - Pin mux selects i_init_*.
  - i_init_done = 1 -> ARBIT on the next edge.
  - i_init_done is sticky; a later deassertion is ignored.
- ARBIT:
  - Pins drive NOP, ba 2'b11, addr all ones.
  - Evaluate in order, registered transition on the next edge:
    - i_aref_req -> AREF.
    - Else both wr and rd requests pending -> WRITE if last_wr = 0, else READ.
    - Else i_wr_req -> WRITE.
    - Else i_rd_req -> READ.
    - Else stay in ARBIT.
  - The matching o_*_en rises on the same edge the state is entered.
  - last_wr is set on entry to WRITE and cleared on entry to READ.
- AREF / WRITE / READ:
  - Pin mux selects the owning module's cmd/ba/addr combinationally. The refresh path uses ba 2'b11.
  - o_*_en stays high until the owner's *_end pulse; it falls on the next edge, with return to ARBIT.
  - All other requests are ignored while busy. They remain pending (levels) and are re-evaluated in ARBIT.
  - ARBIT lasts at least 1 cycle between grants.
- *_end arriving when not in the owner's state is ignored.
- A refresh request arriving during WRITE/READ waits until that transaction's *_end. It then wins in ARBIT even if wr/rd are also pending.
- sdram_dq:
  - Driven with i_wr_sdram_data only when state = WRITE and i_wr_sdram_en = 1; otherwise Z.
  - o_rd_data registers sdram_dq each cycle.
- Exactly one of o_aref_en, o_wr_en, o_rd_en is high at a time, or none.
- Reset mid-operation: all enables drop immediately (asynchronously), pins go to NOP, sdram_dq goes to Z, state returns to INIT.

Test Plan:
- Reset, then hold i_init_done = 0 with i_init_cmd = 4'b0010 -> pins show 0010; o_*_en = 0; sdram_dq = Z.
- Pulse i_init_done, then assert i_wr_req and i_rd_req together -> o_wr_en high 2 cycles after i_init_done; after i_wr_end, one ARBIT NOP cycle, then o_rd_en; next tie grants write again.
- Hold i_aref_req, i_wr_req and i_rd_req simultaneously in ARBIT -> o_aref_en first; after i_aref_end, o_wr_en; refresh pins show i_aref_cmd = 4'b0001.
- In WRITE, toggle i_wr_sdram_en with data 16'hA5A5 -> sdram_dq = A5A5 only while enabled, Z otherwise; o_rd_data follows the model data in READ.
- Assert i_aref_req mid-WRITE -> no grant change until i_wr_end; o_aref_en rises 2 edges after i_wr_end.
- Deassert i_sysrst_n during READ -> o_rd_en = 0 and pins NOP immediately; after release, state stays INIT until i_init_done.
